// File: rtl/uart_apb_pkg.sv
// Shared definitions for the APB UART: register map, bit indices,
// FSM state encodings and the parity helper.
package uart_apb_pkg;

  localparam logic [2:0] REG_TXDATA = 3'd0;
  localparam logic [2:0] REG_RXDATA = 3'd1;
  localparam logic [2:0] REG_BAUD   = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;
  localparam logic [2:0] REG_IRQEN  = 3'd5;

  localparam int CTRL_BIT8     = 0;
  localparam int CTRL_PAR_EN   = 1;
  localparam int CTRL_ODD      = 2;
  localparam int CTRL_TWO_STOP = 3;
  localparam int CTRL_TX_EN    = 4;
  localparam int CTRL_RX_EN    = 5;

  localparam logic [5:0] CTRL_RESET = 6'h30;

  localparam int ST_TX_EMPTY = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_OVF      = 4;
  localparam int ST_TX_BUSY  = 7;
  localparam int ST_TX_LVL   = 8;
  localparam int ST_RX_LVL   = 16;

  localparam int IE_RXNE = 0;
  localparam int IE_TXE  = 1;
  localparam int IE_ERR  = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP1,
    TX_STOP2
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  function automatic logic par_bit(
    input logic [7:0] d,
    input logic       bit8,
    input logic       odd
  );
    logic [7:0] m;
    m = bit8 ? d : {1'b0, d[6:0]};
    return (^m) ^ odd;
  endfunction

endpackage

// File: rtl/uart_apb_if.sv
// APB3 slave bus bundle for the UART register block.
interface uart_apb_if;
  logic [4:0]  PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy level; used for both UART directions.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     PCLK,
  input  logic                     aresetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge PCLK) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge PCLK or negedge aresetn) begin
    if (!aresetn) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_apb_fifo.sv
// APB3 UART with TX/RX FIFOs, programmable baud divisor, optional
// parity and second stop bit, sticky error flags and level IRQ.
module uart_apb_fifo
  import uart_apb_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int BAUD_W      = 16,
  parameter int BAUD_RESET  = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic      PCLK,
  input  logic      aresetn,
  uart_apb_if.slave apb,
  input  logic      RX,
  output logic      TX,
  output logic      IRQ
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic       access, wr, rd;
  logic [2:0] sel;
  logic       is_tx, is_rx, is_baud, is_ctrl, is_st, is_ie;
  logic       unused;

  assign access  = apb.PSEL & apb.PENABLE;
  assign wr      = access & apb.PWRITE;
  assign rd      = access & ~apb.PWRITE;
  assign sel     = apb.PADDR[4:2];
  assign is_tx   = (sel == REG_TXDATA);
  assign is_rx   = (sel == REG_RXDATA);
  assign is_baud = (sel == REG_BAUD);
  assign is_ctrl = (sel == REG_CTRL);
  assign is_st   = (sel == REG_STATUS);
  assign is_ie   = (sel == REG_IRQEN);
  assign unused  = ^{apb.PADDR[1:0], apb.PWDATA[31:8]};

  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = access & (sel[2] & sel[1]);

  logic [BAUD_W-1:0] baud, bcnt;
  logic [5:0]        ctrl;
  logic [2:0]        irq_en;
  logic [2:0]        sticky, sticky_set, sticky_clr;
  logic              tick;
  logic [2:0]        last_bit;

  assign tick     = (bcnt == '0);
  assign last_bit = ctrl[CTRL_BIT8] ? 3'd7 : 3'd6;

  // A BAUD write restarts the divisor so the new rate applies at once.
  always_ff @(posedge PCLK or negedge aresetn) begin
    if (!aresetn) begin
      baud <= BAUD_W'(BAUD_RESET);
      bcnt <= BAUD_W'(BAUD_RESET);
    end else if (wr && is_baud) begin
      baud <= apb.PWDATA[BAUD_W-1:0];
      bcnt <= apb.PWDATA[BAUD_W-1:0];
    end else if (tick) begin
      bcnt <= baud;
    end else begin
      bcnt <= bcnt - BAUD_W'(1);
    end
  end

  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]    tx_head;
  logic [LW-1:0] tx_level;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]    rx_head;
  logic [LW-1:0] rx_level;

  assign tx_push = wr & is_tx & ~tx_full;
  assign rx_pop  = rd & is_rx & ~rx_empty;

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .PCLK    (PCLK),
    .aresetn (aresetn),
    .push    (tx_push),
    .wdata   (apb.PWDATA[7:0]),
    .pop     (tx_pop),
    .rdata   (tx_head),
    .full    (tx_full),
    .empty   (tx_empty),
    .level   (tx_level)
  );

  // ---------------- TX FSM ----------------
  tx_state_e  tx_st, tx_nx;
  logic [3:0] tx_tk;
  logic [2:0] tx_bi;
  logic [7:0] tx_sh;
  logic       tx_par, tx_go, tx_end, tx_busy;

  assign tx_go  = (tx_st == TX_IDLE) & tick &
                  ctrl[CTRL_TX_EN] & ~tx_empty;
  assign tx_end = tick & (tx_tk == 4'd15);

  always_ff @(posedge PCLK or negedge aresetn) begin
    if (!aresetn) tx_st <= TX_IDLE;
    else          tx_st <= tx_nx;
  end

  always_comb begin
    tx_nx = tx_st;
    unique case (tx_st)
      TX_IDLE:   if (tx_go) tx_nx = TX_START;
      TX_START:  if (tx_end) tx_nx = TX_DATA;
      TX_DATA:
        if (tx_end && tx_bi == last_bit)
          tx_nx = ctrl[CTRL_PAR_EN] ? TX_PARITY : TX_STOP1;
      TX_PARITY: if (tx_end) tx_nx = TX_STOP1;
      TX_STOP1:
        if (tx_end)
          tx_nx = ctrl[CTRL_TWO_STOP] ? TX_STOP2 : TX_IDLE;
      TX_STOP2:  if (tx_end) tx_nx = TX_IDLE;
      default:   tx_nx = TX_IDLE;
    endcase
  end

  always_comb begin
    TX      = 1'b1;
    tx_pop  = tx_go;
    tx_busy = (tx_st != TX_IDLE);
    unique case (tx_st)
      TX_START:  TX = 1'b0;
      TX_DATA:   TX = tx_sh[0];
      TX_PARITY: TX = tx_par;
      default:   TX = 1'b1;
    endcase
  end

  always_ff @(posedge PCLK or negedge aresetn) begin
    if (!aresetn) begin
      tx_tk  <= '0;
      tx_bi  <= '0;
      tx_sh  <= '0;
      tx_par <= 1'b0;
    end else if (tx_go) begin
      tx_tk  <= '0;
      tx_bi  <= '0;
      tx_sh  <= tx_head;
      tx_par <= par_bit(tx_head, ctrl[CTRL_BIT8], ctrl[CTRL_ODD]);
    end else if (tick && tx_st != TX_IDLE) begin
      tx_tk <= tx_tk + 4'd1;
      if (tx_end && tx_st == TX_DATA) begin
        tx_sh <= tx_sh >> 1;
        tx_bi <= tx_bi + 3'd1;
      end
    end
  end

  // ---------------- RX FSM ----------------
  logic [SYNC_STAGES-1:0] rx_sync;
  logic                   rx_s, rx_prev;

  always_ff @(posedge PCLK or negedge aresetn) begin
    if (!aresetn) begin
      rx_sync <= '1;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[SYNC_STAGES-2:0], RX};
      rx_prev <= rx_s;
    end
  end

  assign rx_s = rx_sync[SYNC_STAGES-1];

  rx_state_e  rx_st, rx_nx;
  logic [3:0] rx_tk;
  logic [2:0] rx_bi;
  logic [7:0] rx_sh;
  logic       rx_go, rx_mid, rx_end, rx_stop_mid;

  assign rx_go  = (rx_st == RX_IDLE) & ctrl[CTRL_RX_EN] &
                  rx_prev & ~rx_s;
  assign rx_mid = tick & (rx_tk == 4'd7);
  assign rx_end = tick & (rx_tk == 4'd15);

  always_ff @(posedge PCLK or negedge aresetn) begin
    if (!aresetn) rx_st <= RX_IDLE;
    else          rx_st <= rx_nx;
  end

  always_comb begin
    rx_nx = rx_st;
    unique case (rx_st)
      RX_IDLE:   if (rx_go) rx_nx = RX_START;
      RX_START:
        if (rx_mid && rx_s) rx_nx = RX_IDLE;
        else if (rx_end)    rx_nx = RX_DATA;
      RX_DATA:
        if (rx_end && rx_bi == last_bit)
          rx_nx = ctrl[CTRL_PAR_EN] ? RX_PARITY : RX_STOP;
      RX_PARITY: if (rx_end) rx_nx = RX_STOP;
      RX_STOP:   if (rx_mid) rx_nx = RX_IDLE;
      default:   rx_nx = RX_IDLE;
    endcase
  end

  // The frame is committed at mid-stop; a full FIFO drops it.
  always_comb begin
    rx_stop_mid   = (rx_st == RX_STOP) & rx_mid;
    rx_push       = rx_stop_mid & ~rx_full;
    sticky_set    = '0;
    sticky_set[0] = rx_stop_mid & rx_full;
    sticky_set[1] = (rx_st == RX_PARITY) & rx_mid &
                    (par_bit(rx_sh, ctrl[CTRL_BIT8],
                             ctrl[CTRL_ODD]) != rx_s);
    sticky_set[2] = rx_stop_mid & ~rx_s;
  end

  always_ff @(posedge PCLK or negedge aresetn) begin
    if (!aresetn) begin
      rx_tk <= '0;
      rx_bi <= '0;
      rx_sh <= '0;
    end else if (rx_go) begin
      rx_tk <= '0;
      rx_bi <= '0;
      rx_sh <= '0;
    end else if (tick && rx_st != RX_IDLE) begin
      rx_tk <= rx_tk + 4'd1;
      if (rx_mid && rx_st == RX_DATA) rx_sh[rx_bi] <= rx_s;
      if (rx_end && rx_st == RX_DATA) rx_bi <= rx_bi + 3'd1;
    end
  end

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .PCLK    (PCLK),
    .aresetn (aresetn),
    .push    (rx_push),
    .wdata   (rx_sh),
    .pop     (rx_pop),
    .rdata   (rx_head),
    .full    (rx_full),
    .empty   (rx_empty),
    .level   (rx_level)
  );

  // ---------------- registers ----------------
  assign sticky_clr = (wr && is_st) ? apb.PWDATA[ST_OVF +: 3] : '0;

  always_ff @(posedge PCLK or negedge aresetn) begin
    if (!aresetn) begin
      ctrl   <= CTRL_RESET;
      irq_en <= '0;
      sticky <= '0;
      IRQ    <= 1'b0;
    end else begin
      if (wr && is_ctrl) ctrl   <= apb.PWDATA[5:0];
      if (wr && is_ie)   irq_en <= apb.PWDATA[2:0];
      sticky <= (sticky & ~sticky_clr) | sticky_set;
      IRQ    <= (irq_en[IE_ERR]  & |sticky)  |
                (irq_en[IE_TXE]  & tx_empty) |
                (irq_en[IE_RXNE] & ~rx_empty);
    end
  end

  logic [31:0] status;

  always_comb begin
    status                  = '0;
    status[ST_TX_EMPTY]     = tx_empty;
    status[ST_TX_FULL]      = tx_full;
    status[ST_RX_EMPTY]     = rx_empty;
    status[ST_RX_FULL]      = rx_full;
    status[ST_OVF +: 3]     = sticky;
    status[ST_TX_BUSY]      = tx_busy;
    status[ST_TX_LVL +: 8]  = 8'(tx_level);
    status[ST_RX_LVL +: 8]  = 8'(rx_level);
  end

  always_comb begin
    apb.PRDATA = '0;
    if (access) begin
      unique case (1'b1)
        is_rx:   apb.PRDATA = rx_empty ? '0 : {24'b0, rx_head};
        is_baud: apb.PRDATA = 32'(baud);
        is_ctrl: apb.PRDATA = 32'(ctrl);
        is_st:   apb.PRDATA = status;
        is_ie:   apb.PRDATA = 32'(irq_en);
        default: apb.PRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_apb_fifo.sv
// Directed bench for uart_apb_fifo: register map, TX waveform,
// loopback with parity, overflow, framing error and mid-frame reset.
module tb_uart_apb_fifo;

  localparam logic [4:0] A_TX   = 5'h00;
  localparam logic [4:0] A_RX   = 5'h04;
  localparam logic [4:0] A_BAUD = 5'h08;
  localparam logic [4:0] A_CTRL = 5'h0C;
  localparam logic [4:0] A_ST   = 5'h10;
  localparam logic [4:0] A_IE   = 5'h14;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic tx, irq;
  logic loop = 1'b0;
  logic rx_drv = 1'b1;
  logic rx_line;

  int checks = 0;
  int failures = 0;

  uart_apb_if apb();

  assign rx_line = loop ? tx : rx_drv;

  uart_apb_fifo #(
    .FIFO_DEPTH  (4),
    .BAUD_W      (16),
    .BAUD_RESET  (7),
    .SYNC_STAGES (2)
  ) dut (
    .PCLK    (clk),
    .aresetn (aresetn),
    .apb     (apb),
    .RX      (rx_line),
    .TX      (tx),
    .IRQ     (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic apb_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0;
    apb.PWRITE = 1'b1; apb.PADDR = a; apb.PWDATA = d;
    @(negedge clk);
    apb.PENABLE = 1'b1;
    @(posedge clk); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [4:0] a, output logic [31:0] d,
                          output logic e);
    @(negedge clk);
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0;
    apb.PWRITE = 1'b0; apb.PADDR = a;
    @(negedge clk);
    apb.PENABLE = 1'b1;
    #1;
    d = apb.PRDATA;
    e = apb.PSLVERR;
    @(posedge clk); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a,
                        input logic [31:0] exp);
    logic [31:0] d;
    logic e;
    apb_read(a, d, e);
    chk(tag, d, exp);
  endtask

  task automatic wait_st(input string tag, input logic [31:0] mask,
                         input logic [31:0] val, input int budget);
    logic [31:0] d;
    logic e;
    int n;
    n = 0;
    do begin
      apb_read(A_ST, d, e);
      n++;
    end while ((d & mask) != val && n < budget);
    chk(tag, d & mask, val);
  endtask

  initial begin
    logic [31:0] d;
    logic e;
    logic [9:0] fr;
    int lat, errs, n;

    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    apb.PADDR = '0; apb.PWDATA = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_irq", 32'(irq), 32'd0);
    aresetn = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_prdata", apb.PRDATA, 32'h0);
    chk("pready", 32'(apb.PREADY), 32'd1);
    rd_chk("rst_ctrl", A_CTRL, 32'h30);
    rd_chk("rst_status", A_ST, 32'h05);
    rd_chk("rst_baud", A_BAUD, 32'd7);
    rd_chk("rst_irqen", A_IE, 32'h0);
    apb_read(A_ST, d, e);
    chk("ok_slverr", 32'(e), 32'd0);
    apb_read(5'h18, d, e);
    chk("bad18_slverr", 32'(e), 32'd1);
    chk("bad18_prdata", d, 32'h0);
    apb_read(5'h1C, d, e);
    chk("bad1c_slverr", 32'(e), 32'd1);

    // 8N1 TX waveform of 0x55 at BAUD=0
    apb_write(A_BAUD, 32'd0);
    apb_write(A_CTRL, 32'h31);
    apb_write(A_TX, 32'h55);
    lat = 0;
    while (tx === 1'b1 && lat < 3) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("tx_start_lat", 32'(lat <= 2 && tx === 1'b0), 32'd1);
    fr = {1'b1, 8'h55, 1'b0};
    errs = 0;
    fork
      begin
        for (int i = 0; i < 160; i++) begin
          if (i > 0) begin
            @(posedge clk); #1;
          end
          if (tx !== fr[i / 16]) errs++;
        end
      end
      begin
        repeat (30) @(posedge clk);
        apb_read(A_ST, d, e);
        chk("busy_early", 32'(d[7]), 32'd1);
        repeat (100) @(posedge clk);
        apb_read(A_ST, d, e);
        chk("busy_late", 32'(d[7]), 32'd1);
      end
    join
    chk("tx_wave_errs", 32'(errs), 32'd0);
    rd_chk("tx_done_status", A_ST, 32'h05);

    // loopback 8O2 at BAUD=3
    loop = 1'b1;
    apb_write(A_BAUD, 32'd3);
    apb_write(A_CTRL, 32'h3F);
    apb_write(A_TX, 32'hA5);
    apb_write(A_TX, 32'h3C);
    wait_st("loop_rx_level", 32'h00FF_0000, 32'h0002_0000, 1500);
    apb_read(A_ST, d, e);
    chk("loop_errs", 32'(d[6:5]), 32'd0);
    rd_chk("loop_rx0", A_RX, 32'hA5);
    rd_chk("loop_rx1", A_RX, 32'h3C);
    repeat (200) @(posedge clk);

    // overflow with a 4-deep RX FIFO
    apb_write(A_BAUD, 32'd0);
    apb_write(A_CTRL, 32'h31);
    apb_write(A_TX, 32'h11);
    apb_write(A_TX, 32'h22);
    apb_write(A_TX, 32'h33);
    apb_write(A_TX, 32'h44);
    apb_write(A_TX, 32'h55);
    wait_st("ovf_seen", 32'h10, 32'h10, 800);
    repeat (40) @(posedge clk);
    rd_chk("ovf_status", A_ST, 32'h0004_0019);
    apb_write(A_ST, 32'h10);
    rd_chk("ovf_cleared", A_ST, 32'h0004_0009);
    rd_chk("ovf_rx0", A_RX, 32'h11);
    rd_chk("ovf_rx1", A_RX, 32'h22);
    rd_chk("ovf_rx2", A_RX, 32'h33);
    rd_chk("ovf_rx3", A_RX, 32'h44);
    rd_chk("ovf_rx_empty", A_RX, 32'h0);
    rd_chk("ovf_final_st", A_ST, 32'h05);

    // 0x00 frame with a low stop bit
    loop = 1'b0;
    apb_write(A_IE, 32'h4);
    repeat (4) @(posedge clk);
    chk("irq_pre_frm", 32'(irq), 32'd0);
    @(negedge clk);
    rx_drv = 1'b0;
    n = 0;
    fork
      begin
        repeat (160) @(negedge clk);
        rx_drv = 1'b1;
      end
      begin
        while (irq !== 1'b1 && n < 300) begin
          @(posedge clk); #1;
          n++;
        end
      end
    join
    chk("frm_irq_window", 32'(n >= 150 && n <= 160), 32'd1);
    rd_chk("frm_status", A_ST, 32'h0001_0041);
    rd_chk("frm_rxdata", A_RX, 32'h00);
    chk("frm_irq_hold", 32'(irq), 32'd1);

    // reset in the middle of a TX frame
    apb_write(A_TX, 32'h00);
    apb_write(A_TX, 32'h00);
    repeat (50) @(posedge clk);
    #1;
    chk("mid_tx_low", 32'(tx), 32'd0);
    aresetn = 1'b0;
    #1;
    chk("arst_tx", 32'(tx), 32'd1);
    chk("arst_irq", 32'(irq), 32'd0);
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    rd_chk("arst_status", A_ST, 32'h05);
    rd_chk("arst_ctrl", A_CTRL, 32'h30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
